fetch_exec_sequencer: RTL and testbench

- Control sequencer for the 8-bit CPU.
- Steps through T-states and decodes the instruction register opcode into a 16-bit control word.
- The control word drives the program address counter (pc_inc, load_pc, pc_o_en), the MAR, RAM, IR, the A/B registers, the ALU and the output register.
- Sits directly upstream of the program counter and is its sole source of control.

---
 rtl/fetch_exec_sequencer.sv | 171 +++++++++++++++++
 tb/tb_fetch_exec_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_exec_sequencer.sv
// T-state sequencer and control-word decoder for the 8-bit CPU.
// Optional macro SKIP_IDLE_T_EN: return to T1 right after an opcode's last non-empty step.
module fetch_exec_sequencer #(
  parameter int OPC_W = 4,
  parameter int CW_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [OPC_W-1:0] opcode,
  input  logic             flag_c,
  input  logic             flag_z,
  output logic [CW_W-1:0]  ctrl_word,
  output logic [2:0]       t_state,
  output logic             halted
);

`ifdef SKIP_IDLE_T_EN
  localparam bit SKIP_IDLE = 1'b1;
`else
  localparam bit SKIP_IDLE = 1'b0;
`endif

  typedef enum logic [2:0] {
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5,
    T6 = 3'd6
  } t_state_e;

  // Control word bit map
  localparam logic [CW_W-1:0] PC_INC   = CW_W'(1) << 0;
  localparam logic [CW_W-1:0] LOAD_PC  = CW_W'(1) << 1;
  localparam logic [CW_W-1:0] PC_O_EN  = CW_W'(1) << 2;
  localparam logic [CW_W-1:0] MAR_IN   = CW_W'(1) << 3;
  localparam logic [CW_W-1:0] RAM_O_EN = CW_W'(1) << 4;
  localparam logic [CW_W-1:0] RAM_WR   = CW_W'(1) << 5;
  localparam logic [CW_W-1:0] IR_IN    = CW_W'(1) << 6;
  localparam logic [CW_W-1:0] A_IN     = CW_W'(1) << 7;
  localparam logic [CW_W-1:0] A_O_EN   = CW_W'(1) << 8;
  localparam logic [CW_W-1:0] B_IN     = CW_W'(1) << 9;
  localparam logic [CW_W-1:0] ALU_O_EN = CW_W'(1) << 10;
  localparam logic [CW_W-1:0] ALU_SUB  = CW_W'(1) << 11;
  localparam logic [CW_W-1:0] FLAGS_IN = CW_W'(1) << 12;
  localparam logic [CW_W-1:0] OUT_IN   = CW_W'(1) << 13;
  localparam logic [CW_W-1:0] HALT     = CW_W'(1) << 14;

  localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(4'h1);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(4'h2);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(4'h3);
  localparam logic [OPC_W-1:0] OP_STA = OPC_W'(4'h4);
  localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(4'h5);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(4'h6);
  localparam logic [OPC_W-1:0] OP_JC  = OPC_W'(4'h7);
  localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(4'h8);
  localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(4'hE);
  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(4'hF);

  t_state_e        state_q, state_d;
  logic            halted_q, halted_d;
  logic            taken_q, taken_d;
  logic [CW_W-1:0] word;
  logic            jump_now;
  logic            jump_taken;
  logic            opr3;
  t_state_e        last_step;
  logic            end_of_instr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= T1;
      halted_q <= 1'b0;
      taken_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      taken_q  <= taken_d;
    end
  end

  // Branch decision is taken from the flags seen in T3 and held for T4 onward.
  always_comb begin
    jump_now = 1'b0;
    if (opcode == OP_JMP)     jump_now = 1'b1;
    else if (opcode == OP_JC) jump_now = flag_c;
    else if (opcode == OP_JZ) jump_now = flag_z;
    jump_taken = (state_q == T3) ? jump_now : taken_q;
    opr3 = (opcode == OP_LDA) || (opcode == OP_ADD) ||
           (opcode == OP_SUB) || (opcode == OP_STA);
  end

  always_comb begin
    word = '0;
    unique case (state_q)
      T1: word = PC_O_EN | MAR_IN;
      T2: word = RAM_O_EN | IR_IN | PC_INC;
      T3: begin
        if (opr3 || opcode == OP_LDI)   word = PC_O_EN | MAR_IN;
        else if (opcode == OP_JMP || opcode == OP_JC || opcode == OP_JZ)
          word = jump_now ? (PC_O_EN | MAR_IN) : PC_INC;
        else if (opcode == OP_OUT)      word = A_O_EN | OUT_IN;
        else if (opcode == OP_HLT)      word = HALT;
        else                            word = '0;
      end
      T4: begin
        if (opr3)                       word = RAM_O_EN | MAR_IN | PC_INC;
        else if (opcode == OP_LDI)      word = RAM_O_EN | A_IN | PC_INC;
        else if ((opcode == OP_JMP || opcode == OP_JC || opcode == OP_JZ) && taken_q)
          word = RAM_O_EN | LOAD_PC;
        else                            word = '0;
      end
      T5: begin
        if (opcode == OP_LDA)           word = RAM_O_EN | A_IN;
        else if (opcode == OP_ADD || opcode == OP_SUB)
          word = RAM_O_EN | B_IN;
        else if (opcode == OP_STA)      word = A_O_EN | RAM_WR;
        else                            word = '0;
      end
      T6: begin
        if (opcode == OP_ADD)           word = ALU_O_EN | A_IN | FLAGS_IN;
        else if (opcode == OP_SUB)      word = ALU_O_EN | ALU_SUB | A_IN | FLAGS_IN;
        else                            word = '0;
      end
      default: word = '0;
    endcase
  end

  always_comb begin
    last_step = T3;
    if (opcode == OP_LDA || opcode == OP_STA)      last_step = T5;
    else if (opcode == OP_ADD || opcode == OP_SUB) last_step = T6;
    else if (opcode == OP_LDI)                     last_step = T4;
    else if (opcode == OP_JMP || opcode == OP_JC || opcode == OP_JZ)
      last_step = jump_taken ? T4 : T3;
    // opcode is only meaningful from T3 on, so fetch steps never end an instruction early
    end_of_instr = (state_q == T6) ||
                   (SKIP_IDLE && state_q >= T3 && state_q == last_step);
  end

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    taken_d  = taken_q;
    if (halted_q) begin
      state_d = T1;
    end else if (run) begin
      if (state_q == T3) taken_d = jump_now;
      if (state_q == T3 && opcode == OP_HLT) begin
        halted_d = 1'b1;
        state_d  = T1;
      end else if (end_of_instr) begin
        state_d = T1;
      end else begin
        state_d = t_state_e'(state_q + 3'd1);
      end
    end
  end

  always_comb begin
    ctrl_word = '0;
    if (!reset_n)      ctrl_word = '0;
    else if (halted_q) ctrl_word = HALT;
    else if (run)      ctrl_word = word;
  end

  assign t_state = state_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Randomized scoreboard bench for fetch_exec_sequencer against an instruction-level model.
// Honours SKIP_IDLE_T_EN when compiled with the same define as the design.
module tb_fetch_exec_sequencer;

`ifdef SKIP_IDLE_T_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  localparam int W = 20;  // {halted, t_state, ctrl_word}

  localparam logic [15:0] C_PC_INC = 16'h0001, C_LOAD_PC = 16'h0002, C_PC_O = 16'h0004,
                          C_MAR = 16'h0008, C_RAM_O = 16'h0010, C_RAM_WR = 16'h0020,
                          C_IR = 16'h0040, C_A_IN = 16'h0080, C_A_O = 16'h0100,
                          C_B_IN = 16'h0200, C_ALU_O = 16'h0400, C_ALU_SUB = 16'h0800,
                          C_FLAGS = 16'h1000, C_OUT = 16'h2000, C_HALT = 16'h4000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic [3:0]  opcode;
  logic        flag_c, flag_z;
  logic [15:0] ctrl_word;
  logic [2:0]  t_state;
  logic        halted;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  fetch_exec_sequencer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (run),
    .opcode   (opcode),
    .flag_c   (flag_c),
    .flag_z   (flag_z),
    .ctrl_word(ctrl_word),
    .t_state  (t_state),
    .halted   (halted)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: control word for an instruction step, straight from the opcode table
  function automatic logic [15:0] model_word(input logic [3:0] op, input int s, input bit tk);
    logic [15:0] w;
    w = 16'h0000;
    if (s == 1) return C_PC_O | C_MAR;
    if (s == 2) return C_RAM_O | C_IR | C_PC_INC;
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4: begin
        if (s == 3) w = C_PC_O | C_MAR;
        if (s == 4) w = C_RAM_O | C_MAR | C_PC_INC;
        if (s == 5 && op == 4'h1) w = C_RAM_O | C_A_IN;
        if (s == 5 && (op == 4'h2 || op == 4'h3)) w = C_RAM_O | C_B_IN;
        if (s == 5 && op == 4'h4) w = C_A_O | C_RAM_WR;
        if (s == 6 && op == 4'h2) w = C_ALU_O | C_A_IN | C_FLAGS;
        if (s == 6 && op == 4'h3) w = C_ALU_O | C_ALU_SUB | C_A_IN | C_FLAGS;
      end
      4'h5: begin
        if (s == 3) w = C_PC_O | C_MAR;
        if (s == 4) w = C_RAM_O | C_A_IN | C_PC_INC;
      end
      4'h6, 4'h7, 4'h8: begin
        if (tk && s == 3) w = C_PC_O | C_MAR;
        if (tk && s == 4) w = C_RAM_O | C_LOAD_PC;
        if (!tk && s == 3) w = C_PC_INC;
      end
      4'hE: if (s == 3) w = C_A_O | C_OUT;
      4'hF: if (s == 3) w = C_HALT;
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  // Instruction length in steps
  function automatic int model_len(input logic [3:0] op, input bit tk);
    if (op == 4'hF) return 3;
    if (!SKIP) return 6;
    case (op)
      4'h1, 4'h4: return 5;
      4'h2, 4'h3: return 6;
      4'h5, 4'h6: return 4;
      4'h7, 4'h8: return tk ? 4 : 3;
      default:    return 3;
    endcase
  endfunction

  // Driver tasks
  task automatic drive(input logic r, input logic [3:0] op, input logic fc, input logic fz,
                       input logic [W-1:0] e);
    @(posedge clk);
    #1;
    run = r; opcode = op; flag_c = fc; flag_z = fz;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      run = 1'b0;
      exp_q.push_back({1'b0, 3'd1, 16'h0000});
    end
    @(negedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic do_instr(input logic [3:0] op, input int stall_step, input int stall_len,
                          input int abort_step, input int fc3_i, input int fz3_i);
    bit fc3, fz3, tk;
    int n;
    logic [3:0] opv;
    fc3 = (fc3_i < 0) ? 1'($urandom_range(0, 1)) : 1'(fc3_i);
    fz3 = (fz3_i < 0) ? 1'($urandom_range(0, 1)) : 1'(fz3_i);
    tk = (op == 4'h6) || (op == 4'h7 && fc3) || (op == 4'h8 && fz3);
    n = model_len(op, tk);
    for (int s = 1; s <= n; s++) begin
      if (s == abort_step) return;
      // opcode is only defined from T3 on; scramble it during fetch
      opv = (s < 3) ? 4'($urandom_range(0, 15)) : op;
      for (int k = 0; k < ((s == stall_step) ? stall_len : 0); k++)
        drive(1'b0, opv, (s == 3) ? fc3 : 1'($urandom_range(0, 1)),
              (s == 3) ? fz3 : 1'($urandom_range(0, 1)), {1'b0, 3'(s), 16'h0000});
      drive(1'b1, opv, (s == 3) ? fc3 : 1'($urandom_range(0, 1)),
            (s == 3) ? fz3 : 1'($urandom_range(0, 1)), {1'b0, 3'(s), model_word(op, s, tk)});
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e, got;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {halted, t_state, ctrl_word};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL seq @%0t: got halted=%0b t=%0d cw=%h, want halted=%0b t=%0d cw=%h",
                 $time, got[19], got[18:16], got[15:0], e[19], e[18:16], e[15:0]);
      end
      checks++;
      if (($countones({ctrl_word[2], ctrl_word[4], ctrl_word[8], ctrl_word[10]}) > 1) ||
          (ctrl_word[0] && ctrl_word[1])) begin
        failures++;
        $display("FAIL invariant @%0t: cw=%h, want single bus driver and no pc_inc with load_pc",
                 $time, ctrl_word);
      end
    end
  end

  initial begin
    reset_n = 1'b0; run = 1'b0; opcode = 4'h0; flag_c = 1'b0; flag_z = 1'b0;
    do_reset(2);
    // Directed: NOP, ADD, JC not taken / taken, LDA with stall at T4, STA aborted at T5
    do_instr(4'h0, 0, 0, 0, -1, -1);
    do_instr(4'h0, 0, 0, 0, -1, -1);
    do_instr(4'h2, 0, 0, 0, -1, -1);
    do_instr(4'h7, 0, 0, 0, 0, -1);
    do_instr(4'h7, 0, 0, 0, 1, -1);
    do_instr(4'h8, 0, 0, 0, -1, 0);
    do_instr(4'h8, 0, 0, 0, -1, 1);
    do_instr(4'h1, 4, 3, 0, -1, -1);
    do_instr(4'h4, 0, 0, 5, -1, -1);
    do_reset(1);
    do_instr(4'h0, 0, 0, 0, -1, -1);
    // Randomized instruction stream with occasional stalls
    for (int i = 0; i < 200; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 14));
      if ($urandom_range(0, 3) == 0)
        do_instr(op, $urandom_range(1, 6), $urandom_range(1, 3), 0, -1, -1);
      else
        do_instr(op, 0, 0, 0, -1, -1);
    end
    // HLT, then 20 halted cycles, then reset brings it back
    do_instr(4'hF, 0, 0, 0, -1, -1);
    for (int i = 0; i < 20; i++)
      drive(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), {1'b1, 3'd1, C_HALT});
    do_reset(1);
    do_instr(4'h5, 0, 0, 0, -1, -1);
    do_instr(4'hE, 0, 0, 0, -1, -1);
    do_instr(4'h3, 0, 0, 0, -1, -1);
    // Final report
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
